// File: rtl/mux_lut_arbiter.sv
// ---------------------------------------------------------------------------
// mux_lut_arbiter
// Shares one external key/data lookup multiplexer between NR_REQ requesters.
// The block owns the LUT contents (written through the cfg port), arbitrates
// lookups round-robin, drives the shared mux key/lut buses and returns a
// registered response carrying hit/miss status.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       per-requester lookup request
//   req_key_i         requester i key at [KEY_LEN*(i+1)-1 : KEY_LEN*i]
//   req_ready_o       one-hot accept pulse (IDLE only)
//   rsp_valid_o       response valid, held until rsp_ready_i
//   rsp_ready_i       response consumed
//   rsp_id_o          index of the served requester
//   rsp_data_o        mux result, 0 on miss
//   rsp_hit_o         key matched at least one valid entry
//   cfg_we_i          LUT entry write (ignored while cfg_ready_o=0)
//   cfg_idx_i         entry index
//   cfg_key_i         entry key
//   cfg_data_i        entry data
//   cfg_ready_o       write accepted this cycle when cfg_we_i=1
//   mux_key_o         key to the shared mux
//   mux_lut_o         LUT image to the shared mux, entry n = {key, data}
//   mux_out_i         combinational result from the shared mux
// ---------------------------------------------------------------------------
module mux_lut_arbiter #(
    parameter int NR_REQ   = 4,
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NR_REQ-1:0]                   req_valid_i,
    input  logic [NR_REQ*KEY_LEN-1:0]           req_key_i,
    output logic [NR_REQ-1:0]                   req_ready_o,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [$clog2(NR_REQ)-1:0]           rsp_id_o,
    output logic [DATA_LEN-1:0]                 rsp_data_o,
    output logic                                rsp_hit_o,
    input  logic                                cfg_we_i,
    input  logic [$clog2(NR_KEY)-1:0]           cfg_idx_i,
    input  logic [KEY_LEN-1:0]                  cfg_key_i,
    input  logic [DATA_LEN-1:0]                 cfg_data_i,
    output logic                                cfg_ready_o,
    output logic [KEY_LEN-1:0]                  mux_key_o,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] mux_lut_o,
    input  logic [DATA_LEN-1:0]                 mux_out_i
);

    localparam int ID_W  = $clog2(NR_REQ);
    localparam int IDX_W = $clog2(NR_KEY);
    localparam int PAIR  = KEY_LEN + DATA_LEN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state_q;
    logic [ID_W-1:0]       ptr_q;
    logic [KEY_LEN-1:0]    key_q;
    logic [ID_W-1:0]       id_q;
    logic [KEY_LEN-1:0]    ent_key_q  [NR_KEY];
    logic [DATA_LEN-1:0]   ent_data_q [NR_KEY];
    logic [NR_KEY-1:0]     ent_valid_q;
    logic                  rsp_valid_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [DATA_LEN-1:0]   rsp_data_q;
    logic                  rsp_hit_q;

    logic                  grant_found_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic                  hit_s;
    logic [DATA_LEN-1:0]   rsp_data_d;

    // Round-robin pick: first asserted requester at or after ptr+1, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= NR_REQ; k++) begin
            if (!grant_found_s && req_valid_i[ID_W'(ptr_q + ID_W'(k))]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(ptr_q + ID_W'(k));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Hit detection only looks at valid entries; the mux itself cannot tell.
    always_comb begin
        hit_s = 1'b0;
        for (int n = 0; n < NR_KEY; n++) begin
            if (ent_valid_q[n] && (ent_key_q[n] == key_q)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Lookup result: mux output on hit, forced zero on miss.
    always_comb begin
        rsp_data_d = '0;
        if (hit_s) begin
            rsp_data_d = mux_out_i;
        end else begin
            rsp_data_d = '0;
        end
    end

    // Accept pulse: only in IDLE, and a config write takes the cycle instead.
    always_comb begin
        req_ready_o = '0;
        if ((state_q == ST_IDLE) && !cfg_we_i && grant_found_s) begin
            req_ready_o[grant_idx_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // LUT image for the shared mux; invalid entries read as key=0/data=0.
    always_comb begin
        mux_lut_o = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            if (ent_valid_q[n]) begin
                mux_lut_o[n*PAIR +: PAIR] = {ent_key_q[n], ent_data_q[n]};
            end else begin
                mux_lut_o[n*PAIR +: PAIR] = '0;
            end
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign mux_key_o   = key_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_hit_o   = rsp_hit_q;

    // Control FSM, LUT storage and registered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(NR_REQ - 1);
            key_q       <= '0;
            id_q        <= '0;
            ent_valid_q <= '0;
            for (int n = 0; n < NR_KEY; n++) begin
                ent_key_q[n]  <= '0;
                ent_data_q[n] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_we_i) begin
                        ent_key_q[cfg_idx_i]   <= cfg_key_i;
                        ent_data_q[cfg_idx_i]  <= cfg_data_i;
                        ent_valid_q[cfg_idx_i] <= 1'b1;
                    end else if (grant_found_s) begin
                        key_q   <= req_key_i[grant_idx_s*KEY_LEN +: KEY_LEN];
                        id_q    <= grant_idx_s;
                        ptr_q   <= grant_idx_s;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    rsp_data_q  <= rsp_data_d;
                    rsp_hit_q   <= hit_s;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_lut_arbiter.md
Name: mux_lut_arbiter

Overview:
- Shares one key-lookup multiplexer (NR_KEY key/data pairs, flat lut bus) between NR_REQ requesters.
- Owns and configures the LUT contents through a write port.
- Arbitrates lookups round-robin, drives the shared mux key and returns registered responses with hit/miss status.
- The mux itself stays external: this block drives its key and lut inputs and samples its out.

Parameters:
NR_REQ, 4, number of requesters (power of two, ≥2); ID_W = $clog2(NR_REQ), localparam
NR_KEY, 4, number of LUT entries; IDX_W = $clog2(NR_KEY), localparam
KEY_LEN, 2, key width
DATA_LEN, 4, data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NR_REQ  per-requester lookup request
req_key  in  NR_REQ*KEY_LEN  requester i key at [KEY_LEN*(i+1)-1 : KEY_LEN*i]
req_ready  out  NR_REQ  one-hot accept pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_id  out  ID_W  index of served requester
rsp_data  out  DATA_LEN  mux result (0 on miss)
rsp_hit  out  1  key matched a valid entry
cfg_we  in  1  LUT entry write
cfg_idx  in  IDX_W  entry index
cfg_key  in  KEY_LEN  entry key
cfg_data  in  DATA_LEN  entry data
cfg_ready  out  1  write accepted this cycle when cfg_we=1
mux_key  out  KEY_LEN  to shared mux key
mux_lut  out  NR_KEY*(KEY_LEN+DATA_LEN)  to shared mux lut; entry n at [PAIR*(n+1)-1 : PAIR*n], key in upper KEY_LEN bits, data in lower DATA_LEN bits
mux_out  in  DATA_LEN  combinational result from shared mux

Behaviour:
- State machine with three states:
  - IDLE: cfg_ready=1.
    - If cfg_we: write entry cfg_idx (key, data), set valid[cfg_idx]. Issue no grant this cycle; config has priority.
    - Else if any req_valid: grant the first asserted requester at or after ptr+1 (mod NR_REQ), ptr = last granted.
    - On grant: req_ready[g]=1 for that cycle only; latch key_q=req_key[g], id_q=g, ptr←g; go LOOKUP.
  - LOOKUP (1 cycle): mux_key=key_q.
    - hit = OR over n of (valid[n] && key_n==key_q).
    - rsp_data←hit ? mux_out : 0; rsp_hit←hit; rsp_id←id_q; go RESP.
  - RESP: rsp_valid=1, outputs held stable until rsp_ready=1. On that cycle go IDLE; rsp_valid drops next cycle.
- cfg_ready=0 and req_ready=0 outside IDLE. cfg_we while cfg_ready=0 is ignored; the writer must hold it.
- mux_lut mirrors entry registers. Invalid entries are presented as key=0, data=0: zero data contributes nothing to the mux OR-reduction, and rsp_hit ignores them.
- Duplicate valid keys: all matching entries hit; rsp_data is the OR of their data (mux semantics).
- Overwriting an entry replaces both key and data.
- No entry invalidation except reset.
- Latency:
  - Accept at cycle T, rsp_valid at T+2.
  - With rsp_ready held high, next accept at T+3.
  - Throughput is 1 lookup per 3 cycles.
- Requester may drop req_valid before its grant; nothing is owed to it.
- mux_key=key_q in all states; it is only sampled in LOOKUP.
- Reset, any cycle including mid-lookup:
  - state IDLE, ptr=NR_REQ-1 (so requester 0 has first priority).
  - All entries key=0/data=0/invalid.
  - key_q=0, id_q=0.
  - rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_id=0, req_ready=0.
  - cfg_ready=1 from the first cycle after reset.
  - Any in-flight response is discarded.

Test Plan:
- Reset then req_valid=0001, key 2'b01, empty LUT → req_ready=0001 at T; rsp_valid at T+2 with rsp_hit=0, rsp_data=0, rsp_id=0.
- Write idx1 key=2'b10 data=4'hA; req0 key=2'b10 → rsp_hit=1, rsp_data=4'hA, rsp_id=0; mux_lut[11:6]=6'b10_1010.
- req_valid=1111 held constantly, rsp_ready=1 → grants in order 0,1,2,3,0, one every 3 cycles; rsp_id matches the grant sequence.
- Same cycle cfg_we=1 and req_valid=0010 in IDLE → write happens, req_ready=0; grant of req1 the next cycle.
- rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable; cfg_we pulses in that window are ignored (cfg_ready=0) and the LUT is unchanged.
- Entries idx0 key=3 data=4'h1, idx2 key=3 data=4'h4; lookup key 3 → rsp_data=4'h5, hit=1. Assert rst during LOOKUP → rsp_valid=0 next cycle, LUT cleared, next lookup of key 3 misses.
